qam16_demap_ber: RTL and testbench

Receive-side counterpart of the 16-QAM mapper and PRBS-23 bit source. The block takes one hard-decision sample pair per symbol (Q1.11 I/Q, post-matched-filter and downsampled) and slices it to 4 Gray-coded bits. It serializes the bits MSB-first into a self-synchronizing PRBS-23 (x^23 + x^18 + 1) checker, which acquires lock and then counts checked bits and bit errors for BER measurement on the HDMI overlay.

---
 rtl/qam16_demap_ber.sv | 212 +++++++++++++++++++++
 tb/tb_qam16_demap_ber.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qam16_demap_ber.sv
// 16-QAM hard-decision demapper feeding a self-synchronizing PRBS-23 checker.
// Each accepted I/Q pair is sliced to 4 Gray-coded bits. The bits are serialized
// MSB-first into the checker, which hunts for lock and then counts checked bits
// and bit errors for BER measurement.
module qam16_demap_ber #(
   parameter int DATA_WIDTH  = 12,
   parameter int THRESH      = 1296,
   parameter int LOCK_COUNT  = 64,
   parameter int LOSS_WINDOW = 256,
   parameter int LOSS_ERRS   = 32,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] sym_i,
   input  logic [DATA_WIDTH-1:0] sym_q,
   input  logic                  sym_valid,
   output logic                  sym_ready,
   output logic [3:0]            dec_sym,
   output logic                  dec_valid,
   input  logic                  cnt_clr,
   output logic                  lock,
   output logic [CNT_WIDTH-1:0]  bit_cnt,
   output logic [CNT_WIDTH-1:0]  err_cnt
);

   localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
   localparam int WIN_W  = $clog2(LOSS_WINDOW);
   localparam int WERR_W = $clog2(LOSS_WINDOW + 1);

   // Thresholds are one bit wider than the samples so negation cannot overflow.
   localparam logic signed [DATA_WIDTH:0] THR_POS   = (DATA_WIDTH+1)'(THRESH);
   localparam logic signed [DATA_WIDTH:0] THR_NEG   = (DATA_WIDTH+1)'(-THRESH);
   localparam logic [4:0]                 FILL_LEN  = 5'd23;
   localparam logic [RUN_W-1:0]           RUN_LOCK  = RUN_W'(LOCK_COUNT);
   localparam logic [WIN_W-1:0]           WIN_LAST  = WIN_W'(LOSS_WINDOW - 1);
   localparam logic [WERR_W-1:0]          ERR_LIMIT = WERR_W'(LOSS_ERRS);

   typedef enum logic {
      ST_HUNT,
      ST_LOCK
   } state_e;

   // Serializer and output registers
   logic [2:0]            rem_q, rem_d;
   logic [3:0]            shift_q, shift_d;
   logic                  ready_q, ready_d;
   logic [3:0]            decSym_q, decSym_d;
   logic                  decValid_q, decValid_d;

   // Checker registers
   state_e                state_q, state_d;
   logic [22:0]           sr_q, sr_d;
   logic [4:0]            fill_q, fill_d;
   logic [RUN_W-1:0]      run_q, run_d;
   logic [WIN_W-1:0]      win_q, win_d;
   logic [WERR_W-1:0]     winErr_q, winErr_d;
   logic [CNT_WIDTH-1:0]  bitCnt_q, bitCnt_d;
   logic [CNT_WIDTH-1:0]  errCnt_q, errCnt_d;

   logic                  accept;
   logic                  bitValid;
   logic                  rxBit;
   logic                  pred;
   logic                  mis;
   logic [WERR_W-1:0]     winErrSum;
   logic [3:0]            slicedSym;

   // Per-axis Gray slicer: 00=-3, 01=-1, 11=+1, 10=+3; zero slices to +1.
   function automatic logic [1:0] sliceAxis(input logic [DATA_WIDTH-1:0] x);
      logic signed [DATA_WIDTH:0] xs;
      xs = $signed({x[DATA_WIDTH-1], x});
      if (xs <= THR_NEG) begin
         sliceAxis = 2'b00;
      end else if (x[DATA_WIDTH-1]) begin
         sliceAxis = 2'b01;
      end else if (xs < THR_POS) begin
         sliceAxis = 2'b11;
      end else begin
         sliceAxis = 2'b10;
      end
   endfunction

   assign slicedSym = {sliceAxis(sym_i), sliceAxis(sym_q)};
   assign accept    = sym_valid & ready_q;
   assign bitValid  = (rem_q != 3'd0);
   assign rxBit     = shift_q[3];
   assign pred      = sr_q[22] ^ sr_q[17];
   assign mis       = rxBit ^ pred;

   assign sym_ready = ready_q;
   assign dec_sym   = decSym_q;
   assign dec_valid = decValid_q;
   assign lock      = (state_q == ST_LOCK);
   assign bit_cnt   = bitCnt_q;
   assign err_cnt   = errCnt_q;

   // Serializer: a new symbol reloads 4 bits while the last bit of the previous one drains.
   always_comb begin
      rem_d      = rem_q;
      shift_d    = shift_q;
      decSym_d   = decSym_q;
      decValid_d = 1'b0;
      if (bitValid) begin
         rem_d   = rem_q - 3'd1;
         shift_d = {shift_q[2:0], 1'b0};
      end
      if (accept) begin
         rem_d      = 3'd4;
         shift_d    = slicedSym;
         decSym_d   = slicedSym;
         decValid_d = 1'b1;
      end
      ready_d = (rem_d <= 3'd1);
   end

   // Checker FSM: HUNT self-synchronizes on received bits, LOCK free-runs and counts errors.
   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      fill_d    = fill_q;
      run_d     = run_q;
      win_d     = win_q;
      winErr_d  = winErr_q;
      bitCnt_d  = bitCnt_q;
      errCnt_d  = errCnt_q;
      winErrSum = winErr_q + WERR_W'(mis);
      if (bitValid) begin
         case (state_q)
            ST_HUNT: begin
               sr_d = {sr_q[21:0], rxBit};
               if (fill_q != FILL_LEN) begin
                  fill_d = fill_q + 5'd1;
               end else if ((sr_q == 23'd0) || mis) begin
                  run_d = '0;
               end else begin
                  run_d = run_q + RUN_W'(1);
                  if (run_d == RUN_LOCK) begin
                     state_d = ST_LOCK;
                  end
               end
            end
            default: begin
               sr_d = {sr_q[21:0], pred};
               if (bitCnt_q != '1) begin
                  bitCnt_d = bitCnt_q + CNT_WIDTH'(1);
               end
               if (mis && (errCnt_q != '1)) begin
                  errCnt_d = errCnt_q + CNT_WIDTH'(1);
               end
               if (win_q == WIN_LAST) begin
                  win_d    = '0;
                  winErr_d = '0;
                  if (winErrSum >= ERR_LIMIT) begin
                     state_d = ST_HUNT;
                     fill_d  = 5'd0;
                     run_d   = '0;
                  end
               end else begin
                  win_d    = win_q + WIN_W'(1);
                  winErr_d = winErrSum;
               end
            end
         endcase
      end
      if (cnt_clr) begin
         bitCnt_d = '0;
         errCnt_d = '0;
      end
   end

   // Serializer and output register bank; reset drops any pending bits at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q      <= 3'd0;
         shift_q    <= 4'd0;
         ready_q    <= 1'b1;
         decSym_q   <= 4'd0;
         decValid_q <= 1'b0;
      end else begin
         rem_q      <= rem_d;
         shift_q    <= shift_d;
         ready_q    <= ready_d;
         decSym_q   <= decSym_d;
         decValid_q <= decValid_d;
      end
   end

   // Checker state register bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_HUNT;
         sr_q     <= 23'd0;
         fill_q   <= 5'd0;
         run_q    <= '0;
         win_q    <= '0;
         winErr_q <= '0;
         bitCnt_q <= '0;
         errCnt_q <= '0;
      end else begin
         state_q  <= state_d;
         sr_q     <= sr_d;
         fill_q   <= fill_d;
         run_q    <= run_d;
         win_q    <= win_d;
         winErr_q <= winErr_d;
         bitCnt_q <= bitCnt_d;
         errCnt_q <= errCnt_d;
      end
   end

endmodule

// File: tb/tb_qam16_demap_ber.sv
// Scoreboard bench for qam16_demap_ber: the driver pushes expected decoded
// symbols, a monitor pops and compares on every dec_valid strobe, and the
// driver checks lock timing and counter values at known cycles.
module tb_qam16_demap_ber;

   localparam int DW = 12;
   localparam int CW = 32;
   localparam logic [22:0] SEED = 23'h2AB3C1;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic signed [DW-1:0] sym_i;
   logic signed [DW-1:0] sym_q;
   logic                 sym_valid;
   logic                 sym_ready;
   logic [3:0]           dec_sym;
   logic                 dec_valid;
   logic                 cnt_clr;
   logic                 lock;
   logic [CW-1:0]        bit_cnt;
   logic [CW-1:0]        err_cnt;

   int          checks   = 0;
   int          failures = 0;
   logic [3:0]  expQ[$];
   logic [3:0]  expSym;
   logic [22:0] prbsSr;

   // Free-running clock, 10 ns period.
   always #5 clk = ~clk;

   qam16_demap_ber dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .sym_i     (sym_i),
      .sym_q     (sym_q),
      .sym_valid (sym_valid),
      .sym_ready (sym_ready),
      .dec_sym   (dec_sym),
      .dec_valid (dec_valid),
      .cnt_clr   (cnt_clr),
      .lock      (lock),
      .bit_cnt   (bit_cnt),
      .err_cnt   (err_cnt)
   );

   task automatic checkOutput(input string name, input logic [CW-1:0] actual,
                              input logic [CW-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Gray level for one axis: 00=-1943, 01=-648, 11=+648, 10=+1943.
   function automatic logic signed [DW-1:0] levelOf(input logic [1:0] b);
      case (b)
         2'b00:   return -12'sd1943;
         2'b01:   return -12'sd648;
         2'b11:   return 12'sd648;
         default: return 12'sd1943;
      endcase
   endfunction

   // Source-side PRBS-23 generator, MSB-first into a 4-bit symbol.
   task automatic genPrbsSym(output logic [3:0] s);
      logic p;
      s = 4'd0;
      for (int j = 0; j < 4; j++) begin
         p      = prbsSr[22] ^ prbsSr[17];
         prbsSr = {prbsSr[21:0], p};
         s[3-j] = p;
      end
   endtask

   // Waits (bounded) for sym_ready at a falling edge, then offers one sample pair.
   task automatic applyStimulus(input logic signed [DW-1:0] iv, input logic signed [DW-1:0] qv,
                                input logic [3:0] e);
      int guard;
      guard = 0;
      while (sym_ready !== 1'b1 && guard < 16) begin
         @(negedge clk);
         guard++;
      end
      if (sym_ready !== 1'b1) begin
         checks++;
         failures++;
         $display("[TB] FAIL ready_timeout: got sym_ready=%b, expected 1 within 16 cycles", sym_ready);
      end else begin
         sym_valid = 1'b1;
         sym_i     = iv;
         sym_q     = qv;
         expQ.push_back(e);
         @(negedge clk);
         sym_valid = 1'b0;
         sym_i     = 12'sd5;
         sym_q     = -12'sd5;
      end
   endtask

   task automatic sendPrbs(input logic flipI);
      logic [3:0]           s;
      logic signed [DW-1:0] iv;
      genPrbsSym(s);
      iv = levelOf(s[3:2]);
      if (flipI) begin
         iv = -iv;
         applyStimulus(iv, levelOf(s[1:0]), s ^ 4'b1000);
      end else begin
         applyStimulus(iv, levelOf(s[1:0]), s);
      end
   endtask

   task automatic drain();
      repeat (4) @(negedge clk);
   endtask

   task automatic doReset();
      sym_valid = 1'b0;
      cnt_clr   = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // From a fresh HUNT: lock must rise exactly one cycle after the 87th bit.
   task automatic acquire();
      prbsSr = SEED;
      for (int k = 0; k < 22; k++) begin
         sendPrbs(1'b0);
         checkOutput("lock_low_in_hunt", 32'(lock), 0);
      end
      @(negedge clk);
      checkOutput("lock_low_bit86", 32'(lock), 0);
      @(negedge clk);
      checkOutput("lock_low_bit87", 32'(lock), 0);
      @(negedge clk);
      checkOutput("lock_rise", 32'(lock), 1);
      checkOutput("bit_cnt_at_lock", bit_cnt, 0);
      @(negedge clk);
      checkOutput("bit_cnt_first_locked", bit_cnt, 1);
      checkOutput("err_cnt_first_locked", err_cnt, 0);
   endtask

   // Monitor: every dec_valid strobe must match the oldest pending expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && dec_valid === 1'b1) begin
         if (expQ.size() == 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL dec_valid_extra: got strobe with dec_sym=%h, expected none", dec_sym);
         end else begin
            expSym = expQ.pop_front();
            checkOutput("dec_sym", 32'(dec_sym), 32'(expSym));
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 500 us");
      $fatal(1, "[TB] watchdog expired");
   end

   // Main stimulus sequence.
   initial begin
      logic signed [DW-1:0] cornerVal [8];
      logic [1:0]           cornerExp [8];
      logic [3:0]           r;
      int                   lostAt;

      cornerVal = '{-12'sd1943, -12'sd1296, -12'sd1295, -12'sd1, 12'sd0, 12'sd1295, 12'sd1296, 12'sd1943};
      cornerExp = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b11, 2'b11, 2'b10, 2'b10};

      sym_i     = '0;
      sym_q     = '0;
      sym_valid = 1'b0;
      cnt_clr   = 1'b0;
      rst_n     = 1'b0;
      repeat (2) @(negedge clk);
      checkOutput("reset_sym_ready", 32'(sym_ready), 1);
      checkOutput("reset_dec_valid", 32'(dec_valid), 0);
      checkOutput("reset_dec_sym", 32'(dec_sym), 0);
      checkOutput("reset_lock", 32'(lock), 0);
      checkOutput("reset_bit_cnt", bit_cnt, 0);
      checkOutput("reset_err_cnt", err_cnt, 0);
      rst_n = 1'b1;
      @(negedge clk);

      $display("[TB] all-zero stream");
      for (int k = 0; k < 40; k++) begin
         applyStimulus(-12'sd1943, -12'sd1943, 4'b0000);
      end
      drain();
      checkOutput("zero_lock", 32'(lock), 0);
      checkOutput("zero_bit_cnt", bit_cnt, 0);
      checkOutput("zero_err_cnt", err_cnt, 0);

      $display("[TB] slicer corners");
      doReset();
      for (int k = 0; k < 8; k++) begin
         applyStimulus(cornerVal[k], cornerVal[k], {cornerExp[k], cornerExp[k]});
      end
      applyStimulus(12'sd1943, -12'sd648, 4'b1001);
      drain();

      $display("[TB] clean acquisition");
      doReset();
      acquire();
      sendPrbs(1'b0);
      checkOutput("ready_n1", 32'(sym_ready), 0);
      @(negedge clk);
      checkOutput("ready_n2", 32'(sym_ready), 0);
      @(negedge clk);
      checkOutput("ready_n3", 32'(sym_ready), 0);
      @(negedge clk);
      checkOutput("ready_n4", 32'(sym_ready), 1);
      for (int k = 0; k < 17; k++) begin
         sendPrbs(1'b0);
      end
      drain();
      checkOutput("clean_bit_cnt", bit_cnt, 73);
      checkOutput("clean_err_cnt", err_cnt, 0);
      checkOutput("clean_lock", 32'(lock), 1);

      $display("[TB] single error injection");
      sendPrbs(1'b1);
      for (int k = 0; k < 10; k++) begin
         sendPrbs(1'b0);
      end
      drain();
      checkOutput("inject_err_cnt", err_cnt, 1);
      checkOutput("inject_bit_cnt", bit_cnt, 117);
      checkOutput("inject_lock", 32'(lock), 1);

      $display("[TB] clear versus error in same cycle");
      sendPrbs(1'b1);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      checkOutput("clr_err_cnt", err_cnt, 0);
      checkOutput("clr_bit_cnt", bit_cnt, 0);
      repeat (3) @(negedge clk);
      checkOutput("after_clr_bit_cnt", bit_cnt, 3);
      checkOutput("after_clr_err_cnt", err_cnt, 0);

      $display("[TB] loss of lock on random symbols");
      lostAt = -1;
      for (int k = 0; k < 200 && lostAt < 0; k++) begin
         r = 4'($urandom_range(0, 15));
         applyStimulus(levelOf(r[3:2]), levelOf(r[1:0]), r);
         if (lock === 1'b0) lostAt = k;
      end
      checkOutput("lock_loss_symbol", 32'(lostAt), 34);
      for (int k = 0; k < 4; k++) begin
         r = 4'($urandom_range(0, 15));
         applyStimulus(levelOf(r[3:2]), levelOf(r[1:0]), r);
      end
      drain();
      checkOutput("hunt_bit_cnt_held", bit_cnt, 138);
      checkOutput("hunt_lock", 32'(lock), 0);

      $display("[TB] re-acquisition");
      for (int k = 0; k < 30; k++) begin
         sendPrbs(1'b0);
      end
      drain();
      checkOutput("reacquire_lock", 32'(lock), 1);

      $display("[TB] reset during serialization");
      sendPrbs(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_sym_ready", 32'(sym_ready), 1);
      checkOutput("midrst_lock", 32'(lock), 0);
      checkOutput("midrst_bit_cnt", bit_cnt, 0);
      checkOutput("midrst_err_cnt", err_cnt, 0);
      checkOutput("midrst_dec_valid", 32'(dec_valid), 0);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      acquire();
      drain();

      checkOutput("scoreboard_empty", 32'(expQ.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
